display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
- Decides which 12-bit BCD value the 3-digit seven-segment display multiplexer shows.
- Rotates between score, countdown timer and high score on a fixed dwell time.
- Lets a one-shot alert value (e.g. "hit" bonus, game-over code) pre-empt the rotation for a fixed hold time.
- Sits between the game core and the display multiplexer; its output drives the multiplexer's 12-bit number input directly.

Parameters:
- TICK_DIV, 50000: clk cycles per tick (1 ms at 50 MHz).
- DWELL_TICKS, 2000: ticks each rotating source is shown.
- ALERT_TICKS, 1000: ticks an accepted alert holds the display.
- BLINK_TICKS, 250: half-period of alert blink, in ticks; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- score_bcd  in  12  source 0, 3 BCD digits
- timer_bcd  in  12  source 1
- hiscore_bcd  in  12  source 2
- rot_en  in  3  bit i=1 puts source i in rotation
- alert_req  in  1  level request, alert pending
- alert_bcd  in  12  alert value, sampled on accept
- alert_ack  out  1  one-cycle pulse, alert accepted
- disp_bcd  out  12  value to display multiplexer
- disp_src  out  2  0/1/2 = source shown, 3 = alert or idle
- disp_blank  out  1  1 = downstream blanks all digits

Interface rules:
- Single clock clk; reset rst_n is asynchronous, active-low.
- All outputs are registered.

Behaviour:
- Reset values:
  - disp_bcd=12'h000, disp_src=3, disp_blank=0, alert_ack=0.
  - State IDLE; prescaler, dwell counter and alert counter = 0; cur_src=0.
- Prescaler:
  - Free-running count 0..TICK_DIV-1.
  - tick pulses one cycle when count==TICK_DIV-1, then count wraps to 0.
- Sanitising: every nibble >9 in any input (sources and alert) is saturated to 9 before reaching disp_bcd, so the multiplexer never sees an invalid code.
- State IDLE:
  - Outputs: disp_src=3, disp_bcd=0.
  - rot_en!=0 -> SHOW at the lowest enabled index, dwell counter cleared.
- State SHOW:
  - disp_bcd follows the selected source live with 1-cycle latency; disp_src=cur_src.
  - Dwell counter increments on tick; at DWELL_TICKS-1 plus a tick, advance to the next enabled source in order 0->1->2->0 (skip disabled) and clear the counter.
  - If only one source is enabled, it stays shown and the counter still wraps.
  - rot_en clears cur_src's bit -> next cycle advance to the next enabled source, counter cleared.
  - rot_en==0 -> IDLE next cycle.
- Alert accept:
  - In IDLE or SHOW with alert_req=1: latch sanitised alert_bcd, pulse alert_ack for 1 cycle, enter ALERT.
  - Save cur_src; clear the alert counter.
  - Accept has priority over a same-cycle dwell advance; the advance is discarded.
- State ALERT:
  - Outputs: disp_bcd=latched value, disp_src=3.
  - Alert counter increments on tick.
  - alert_req is ignored and not acked while in ALERT; a request still high at exit is accepted on the first cycle after exit (back-to-back alerts allowed).
  - Exit after ALERT_TICKS ticks: return to the saved source if still enabled, else the next enabled one, else IDLE. Dwell counter cleared.
- Counting: all counters are wide enough for their parameter (clog2); no overflow path.
- Reset mid-operation: asynchronous return to reset values; any latched alert is lost and is not acked again.

Optional Feature:
- Macro: DISPLAY_ARBITER_ALERT_BLINK_EN.
- Defined:
  - In ALERT, disp_blank toggles every BLINK_TICKS ticks, starting at 0 on entry.
  - disp_blank is forced to 0 on exit and in every other state.
- Not defined: disp_blank is tied to 0; no blink counter is built.

Test Plan (TICK_DIV=4, DWELL_TICKS=3, ALERT_TICKS=2, BLINK_TICKS=1):
- Rotation:
  - Stimulus: rot_en=3'b111; score=12'h123, timer=12'h045, hiscore=12'h999; release reset.
  - Required: disp_src sequence 0,1,2,0; each shown for 12 clk; disp_bcd matches its source 1 clk after the switch.
- Skip and disable:
  - Stimulus: rot_en=3'b101, then clear bit 0 while source 0 is shown.
  - Required: 1 is never shown; next cycle disp_src=2; rot_en=0 gives disp_src=3, disp_bcd=0.
- Alert pre-emption:
  - Stimulus: alert_req held with alert_bcd=12'h7A0 mid-dwell of source 1.
  - Required: one alert_ack pulse; disp_bcd=12'h790 (nibble A saturated) for 8 clk; then source 1 resumes with a full 12-clk dwell.
- Back-to-back and same-cycle:
  - Stimulus: alert_req held across exit; separately, alert_req asserted on the cycle of a dwell advance.
  - Required: second ack on the first post-exit cycle; alert wins and the advance is dropped.
- Async reset mid-ALERT:
  - Stimulus: rst_n pulsed low between clock edges.
  - Required: outputs reach reset values immediately, with no clk edge needed.
- Blink:
  - Stimulus: build with DISPLAY_ARBITER_ALERT_BLINK_EN defined and raise an alert.
  - Required: disp_blank = 0,1 over 4-clk ticks, and 0 after exit; without the macro, disp_blank is constant 0.

Source files
------------

// File: rtl/display_arbiter.sv
// Chooses the 3-digit BCD value for the seven-segment multiplexer: timed rotation over
// score/timer/hiscore with a one-shot alert pre-emption. Optional: DISPLAY_ARBITER_ALERT_BLINK_EN.
module display_arbiter #(
  parameter int TICK_DIV    = 50000,
  parameter int DWELL_TICKS = 2000,
  parameter int ALERT_TICKS = 1000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] score_bcd,
  input  logic [11:0] timer_bcd,
  input  logic [11:0] hiscore_bcd,
  input  logic [2:0]  rot_en,
  input  logic        alert_req,
  input  logic [11:0] alert_bcd,
  output logic        alert_ack,
  output logic [11:0] disp_bcd,
  output logic [1:0]  disp_src,
  output logic        disp_blank
);

  localparam int PW = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int AW = (ALERT_TICKS > 1) ? $clog2(ALERT_TICKS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_TICKS - 1);
  localparam logic [AW-1:0] ALERT_MAX = AW'(ALERT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ALERT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cur_src_q, cur_src_d;
  logic [1:0]    saved_src_q, saved_src_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [11:0]   alert_val_q, alert_val_d;
  logic [11:0]   disp_bcd_q, disp_bcd_d;
  logic [1:0]    disp_src_q, disp_src_d;
  logic          ack_q, ack_d;
  logic          tick;
  logic          accept;
  logic [11:0]   src_raw;

  // Any nibble above 9 is clamped to 9 so the digit decoder only ever sees legal BCD.
  function automatic logic [11:0] sat_bcd(input logic [11:0] v);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd9 : v[i*4 +: 4];
    end
    return r;
  endfunction

  // Next enabled source after cur in 0->1->2->0 order; falls back to cur itself.
  function automatic logic [1:0] next_en(input logic [1:0] cur, input logic [2:0] en);
    logic [1:0] n1, n2;
    n1 = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
    n2 = (n1  == 2'd2) ? 2'd0 : n1  + 2'd1;
    if (en[n1])      return n1;
    else if (en[n2]) return n2;
    else             return cur;
  endfunction

  function automatic logic [1:0] lowest_en(input logic [2:0] en);
    if (en[0])      return 2'd0;
    else if (en[1]) return 2'd1;
    else            return 2'd2;
  endfunction

  assign tick   = (presc_q == PRESC_MAX);
  assign accept = (state_q != ALERT) && alert_req;

  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    saved_src_d = saved_src_q;
    dwell_d     = dwell_q;
    acnt_d      = acnt_q;
    alert_val_d = alert_val_q;
    ack_d       = 1'b0;

    if (accept) begin
      // Accept beats any same-cycle rotation step; cur_src is kept as the resume point.
      state_d     = ALERT;
      alert_val_d = sat_bcd(alert_bcd);
      ack_d       = 1'b1;
      saved_src_d = cur_src_q;
      acnt_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rot_en != 3'b000) begin
            state_d   = SHOW;
            cur_src_d = lowest_en(rot_en);
            dwell_d   = '0;
          end
        end
        SHOW: begin
          if (rot_en == 3'b000) begin
            state_d = IDLE;
          end else if (!rot_en[cur_src_q]) begin
            cur_src_d = next_en(cur_src_q, rot_en);
            dwell_d   = '0;
          end else if (tick) begin
            if (dwell_q == DWELL_MAX) begin
              cur_src_d = next_en(cur_src_q, rot_en);
              dwell_d   = '0;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end
        ALERT: begin
          if (tick) begin
            if (acnt_q == ALERT_MAX) begin
              dwell_d = '0;
              if (rot_en[saved_src_q]) begin
                state_d   = SHOW;
                cur_src_d = saved_src_q;
              end else if (rot_en != 3'b000) begin
                state_d   = SHOW;
                cur_src_d = next_en(saved_src_q, rot_en);
              end else begin
                state_d = IDLE;
              end
            end else begin
              acnt_d = acnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    case (cur_src_d)
      2'd0:    src_raw = score_bcd;
      2'd1:    src_raw = timer_bcd;
      2'd2:    src_raw = hiscore_bcd;
      default: src_raw = score_bcd;
    endcase

    // Outputs are derived from the next state so they register in step with it.
    disp_bcd_d = 12'h000;
    disp_src_d = 2'd3;
    case (state_d)
      SHOW: begin
        disp_bcd_d = sat_bcd(src_raw);
        disp_src_d = cur_src_d;
      end
      ALERT: begin
        disp_bcd_d = alert_val_d;
        disp_src_d = 2'd3;
      end
      default: begin
        disp_bcd_d = 12'h000;
        disp_src_d = 2'd3;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_src_q   <= 2'd0;
      saved_src_q <= 2'd0;
      presc_q     <= '0;
      dwell_q     <= '0;
      acnt_q      <= '0;
      alert_val_q <= 12'h000;
      disp_bcd_q  <= 12'h000;
      disp_src_q  <= 2'd3;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      saved_src_q <= saved_src_d;
      presc_q     <= presc_d;
      dwell_q     <= dwell_d;
      acnt_q      <= acnt_d;
      alert_val_q <= alert_val_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_src_q  <= disp_src_d;
      ack_q       <= ack_d;
    end
  end

  assign alert_ack = ack_q;
  assign disp_bcd  = disp_bcd_q;
  assign disp_src  = disp_src_q;

`ifdef DISPLAY_ARBITER_ALERT_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blank_q, blank_d;

  // Blink phase lives only while staying in ALERT; entry and exit both force it to 0.
  always_comb begin
    blink_cnt_d = '0;
    blank_d     = 1'b0;
    if ((state_q == ALERT) && (state_d == ALERT)) begin
      blink_cnt_d = blink_cnt_q;
      blank_d     = blank_q;
      if (tick) begin
        if (blink_cnt_q == BLINK_MAX) begin
          blink_cnt_d = '0;
          blank_d     = ~blank_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign disp_blank = blank_q;
`else
  // Keeps BLINK_TICKS referenced when the blink logic is not built.
  logic unused_blink;
  assign unused_blink = (BLINK_TICKS > 0);
  assign disp_blank   = 1'b0;
`endif

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with TICK_DIV=4, DWELL_TICKS=3, ALERT_TICKS=2, BLINK_TICKS=1.
// Edge En is the n-th rising clk edge after rst_n release; ticks land on edges E4k.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] score_bcd, timer_bcd, hiscore_bcd, alert_bcd;
  logic [2:0]  rot_en;
  logic        alert_req;
  logic        alert_ack;
  logic [11:0] disp_bcd;
  logic [1:0]  disp_src;
  logic        disp_blank;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

`ifdef DISPLAY_ARBITER_ALERT_BLINK_EN
  localparam logic EXP_BLINK = 1'b1;
`else
  localparam logic EXP_BLINK = 1'b0;
`endif

  display_arbiter #(
    .TICK_DIV(4), .DWELL_TICKS(3), .ALERT_TICKS(2), .BLINK_TICKS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .score_bcd(score_bcd), .timer_bcd(timer_bcd), .hiscore_bcd(hiscore_bcd),
    .rot_en(rot_en), .alert_req(alert_req), .alert_bcd(alert_bcd),
    .alert_ack(alert_ack), .disp_bcd(disp_bcd), .disp_src(disp_src),
    .disp_blank(disp_blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after edge En.
  task automatic at_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    score_bcd = 12'h123; timer_bcd = 12'h045; hiscore_bcd = 12'h999;
    rot_en = 3'b111; alert_req = 1'b0; alert_bcd = 12'h7A0;
    #12;
    chk("rst_src",   16'(disp_src),   16'd3);
    chk("rst_bcd",   16'(disp_bcd),   16'h000);
    chk("rst_ack",   16'(alert_ack),  16'd0);
    chk("rst_blank", 16'(disp_blank), 16'd0);
    #10 rst_n = 1'b1;

    // Rotation 0,1,2,0
    at_edge(1);  chk("rot_e1_src", 16'(disp_src), 16'd0); chk("rot_e1_bcd", 16'(disp_bcd), 16'h123);
    at_edge(11); chk("rot_e11_src", 16'(disp_src), 16'd0);
    at_edge(12); chk("rot_e12_src", 16'(disp_src), 16'd1); chk("rot_e12_bcd", 16'(disp_bcd), 16'h045);
    at_edge(23); chk("rot_e23_src", 16'(disp_src), 16'd1);
    at_edge(24); chk("rot_e24_src", 16'(disp_src), 16'd2); chk("rot_e24_bcd", 16'(disp_bcd), 16'h999);
    at_edge(35); chk("rot_e35_src", 16'(disp_src), 16'd2);
    at_edge(36); chk("rot_e36_src", 16'(disp_src), 16'd0); chk("rot_e36_bcd", 16'(disp_bcd), 16'h123);

    // Live follow with one-cycle latency and nibble saturation
    score_bcd = 12'h1F3;
    #1 chk("live_hold_bcd", 16'(disp_bcd), 16'h123);
    at_edge(37); chk("live_sat_bcd", 16'(disp_bcd), 16'h193);
    score_bcd = 12'h123;

    // Alert pre-empts source 1 mid-dwell, accepted on tick edge E52
    at_edge(47); chk("pre_e47_src", 16'(disp_src), 16'd0);
    at_edge(48); chk("pre_e48_src", 16'(disp_src), 16'd1);
    at_edge(51); alert_bcd = 12'h7A0; alert_req = 1'b1;
    at_edge(52);
    chk("al_ack",   16'(alert_ack),  16'd1);
    chk("al_src",   16'(disp_src),   16'd3);
    chk("al_bcd",   16'(disp_bcd),   16'h790);
    chk("al_blank0",16'(disp_blank), 16'd0);
    alert_req = 1'b0;
    at_edge(53); chk("al_ack_once", 16'(alert_ack), 16'd0); chk("al_e53_bcd", 16'(disp_bcd), 16'h790);
    at_edge(57); chk("al_blank1", 16'(disp_blank), 16'(EXP_BLINK)); chk("al_e57_src", 16'(disp_src), 16'd3);
    at_edge(59); chk("al_e59_bcd", 16'(disp_bcd), 16'h790);
    at_edge(60);
    chk("al_exit_src",   16'(disp_src),   16'd1);
    chk("al_exit_bcd",   16'(disp_bcd),   16'h045);
    chk("al_exit_blank", 16'(disp_blank), 16'd0);
    at_edge(71); chk("resume_e71_src", 16'(disp_src), 16'd1);
    at_edge(72); chk("resume_e72_src", 16'(disp_src), 16'd2);

    // Back-to-back alerts with request held across exit
    at_edge(73); alert_req = 1'b1;
    at_edge(74); chk("b2b_ack1", 16'(alert_ack), 16'd1); chk("b2b_src1", 16'(disp_src), 16'd3);
    at_edge(77); chk("b2b_ignored", 16'(alert_ack), 16'd0);
    at_edge(80);
    chk("b2b_exit_src", 16'(disp_src), 16'd2);
    chk("b2b_exit_ack", 16'(alert_ack), 16'd0);
    chk("b2b_exit_bcd", 16'(disp_bcd), 16'h999);
    alert_bcd = 12'hB05;
    at_edge(81);
    chk("b2b_ack2", 16'(alert_ack), 16'd1);
    chk("b2b_src2", 16'(disp_src), 16'd3);
    chk("b2b_bcd2", 16'(disp_bcd), 16'h905);
    alert_req = 1'b0;
    at_edge(87); chk("b2b_e87_src", 16'(disp_src), 16'd3);
    at_edge(88); chk("b2b_e88_src", 16'(disp_src), 16'd2);

    // Alert on the same cycle as a dwell advance (E100): advance dropped
    at_edge(99); chk("same_e99_src", 16'(disp_src), 16'd2); alert_req = 1'b1;
    at_edge(100); chk("same_ack", 16'(alert_ack), 16'd1); chk("same_src", 16'(disp_src), 16'd3);
    alert_req = 1'b0;
    at_edge(108); chk("same_resume_src", 16'(disp_src), 16'd2);
    at_edge(119); chk("same_e119_src", 16'(disp_src), 16'd2);
    at_edge(120); chk("same_e120_src", 16'(disp_src), 16'd0);

    // Skip disabled source 1, then disable the shown source, then all
    rot_en = 3'b101;
    at_edge(131); chk("skip_e131_src", 16'(disp_src), 16'd0);
    at_edge(132); chk("skip_e132_src", 16'(disp_src), 16'd2);
    at_edge(144); chk("skip_e144_src", 16'(disp_src), 16'd0);
    at_edge(145); rot_en = 3'b100;
    at_edge(146); chk("dis_src", 16'(disp_src), 16'd2); chk("dis_bcd", 16'(disp_bcd), 16'h999);
    at_edge(147); rot_en = 3'b000;
    at_edge(148); chk("idle_src", 16'(disp_src), 16'd3); chk("idle_bcd", 16'(disp_bcd), 16'h000);

    // Asynchronous reset in the middle of an alert
    rot_en = 3'b111;
    at_edge(149); chk("reidle_src", 16'(disp_src), 16'd0); chk("reidle_bcd", 16'(disp_bcd), 16'h123);
    alert_bcd = 12'h7A0; alert_req = 1'b1;
    at_edge(150); chk("ar_ack", 16'(alert_ack), 16'd1); chk("ar_bcd", 16'(disp_bcd), 16'h790);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rst_bcd",   16'(disp_bcd),   16'h000);
    chk("ar_rst_src",   16'(disp_src),   16'd3);
    chk("ar_rst_ack",   16'(alert_ack),  16'd0);
    chk("ar_rst_blank", 16'(disp_blank), 16'd0);
    alert_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    at_edge(1); chk("ar_post_src", 16'(disp_src), 16'd0); chk("ar_post_ack", 16'(alert_ack), 16'd0);
    at_edge(3); chk("ar_noreack", 16'(alert_ack), 16'd0); chk("ar_post_bcd", 16'(disp_bcd), 16'h123);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
